// File: rtl/lowbit_pkg.sv
// ---------------------------------------------------------------------------
// lowbit_pkg
// Shared definitions for the bit-serial low-bit convolution core:
//   - decode2        : 2-bit signed-odd code -> value in {-3,-1,+1,+3}
//   - bits_to_slices : operand bit width -> number of 2-bit slices (+ illegal flag)
//   - state_t        : core FSM states
//   - MAX_SLICES     : largest slice count (16-bit operands)
// ---------------------------------------------------------------------------
package lowbit_pkg;

   localparam int MAX_SLICES = 8;
   localparam int OPND_W     = 16;                   // full operand width per lane
   localparam int SLICE_W    = $clog2(MAX_SLICES);   // slice index width
   localparam int SCNT_W     = SLICE_W + 1;          // slice count width (1..MAX_SLICES)

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COMP = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   typedef struct packed {
      logic [SCNT_W-1:0] slices;
      logic              illegal;
   } slice_cfg_t;

   // Codes map onto odd values so every slice is non-zero and symmetric.
   function automatic logic signed [2:0] decode2(input logic [1:0] code);
      logic signed [2:0] val;
      case (code)
         2'b00:   val = 3'sb101;   // -3
         2'b01:   val = 3'sb111;   // -1
         2'b10:   val = 3'sb001;   // +1
         2'b11:   val = 3'sb011;   // +3
         default: val = 3'sb000;
      endcase
      return val;
   endfunction

   // Unsupported widths fall back to a single slice and raise the flag.
   function automatic slice_cfg_t bits_to_slices(input logic [4:0] bits);
      slice_cfg_t cfg;
      cfg.illegal = 1'b0;
      case (bits)
         5'd2:    cfg.slices = 4'd1;
         5'd4:    cfg.slices = 4'd2;
         5'd8:    cfg.slices = 4'd4;
         5'd16:   cfg.slices = 4'd8;
         default: begin
            cfg.slices  = 4'd1;
            cfg.illegal = 1'b1;
         end
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/conv_core_bitserial_if.sv
// ---------------------------------------------------------------------------
// conv_core_bitserial_if
// Beat input and result output channels of the bit-serial conv core.
//   in_valid/in_ready/in_first/in_last : input beat handshake and group markers
//   act, wgt                            : packed 16-bit operands per tap / lane
//   act_bits, wgt_bits                  : operand widths, used on in_first beats
//   out_valid/out_ready/partial         : result handshake and per-OC result
// master = upstream/downstream side, slave = the core.
// ---------------------------------------------------------------------------
interface conv_core_bitserial_if #(
   parameter int IC_LANES = 16,
   parameter int OC_LANES = 16,
   parameter int KH       = 3,
   parameter int KW       = 3,
   parameter int ACC_W    = 48
);
   logic                                               in_valid;
   logic                                               in_ready;
   logic                                               in_first;
   logic                                               in_last;
   logic [KH-1:0][KW-1:0][IC_LANES-1:0][15:0]          act;
   logic [OC_LANES-1:0][KH-1:0][KW-1:0][IC_LANES-1:0][15:0] wgt;
   logic [4:0]                                         act_bits;
   logic [4:0]                                         wgt_bits;
   logic                                               out_valid;
   logic                                               out_ready;
   logic [OC_LANES-1:0][ACC_W-1:0]                     partial;

   modport master (
      output in_valid, in_first, in_last, act, wgt, act_bits, wgt_bits, out_ready,
      input  in_ready, out_valid, partial
   );

   modport slave (
      input  in_valid, in_first, in_last, act, wgt, act_bits, wgt_bits, out_ready,
      output in_ready, out_valid, partial
   );
endinterface

// File: rtl/conv_slice_dot.sv
// ---------------------------------------------------------------------------
// conv_slice_dot
// Combinational signed dot product of N_TAPS pairs of 2-bit codes.
//   a_codes : activation slice codes, one per tap
//   w_codes : weight slice codes, one per tap
//   dot     : sum of decode2(a)*decode2(w), signed DOT_W bits
// ---------------------------------------------------------------------------
module conv_slice_dot
   import lowbit_pkg::*;
#(
   parameter int N_TAPS = 144,
   parameter int DOT_W  = $clog2(9*N_TAPS) + 2
) (
   input  logic [N_TAPS-1:0][1:0] a_codes,
   input  logic [N_TAPS-1:0][1:0] w_codes,
   output logic signed [DOT_W-1:0] dot
);

   logic signed [2:0] da_s;
   logic signed [2:0] dw_s;
   logic [4:0]        prod_s;
   logic [DOT_W-1:0]  sum_s;

   // Adder tree over all taps; products are in [-9,9] so 5 bits suffice.
   always_comb begin
      da_s   = 3'sb000;
      dw_s   = 3'sb000;
      prod_s = 5'd0;
      sum_s  = '0;
      for (int i = 0; i < N_TAPS; i++) begin
         da_s   = decode2(a_codes[i]);
         dw_s   = decode2(w_codes[i]);
         // Low 5 bits of the product are the same signed or unsigned.
         prod_s = {{2{da_s[2]}}, da_s} * {{2{dw_s[2]}}, dw_s};
         sum_s  = sum_s + {{(DOT_W-5){prod_s[4]}}, prod_s};
      end
   end

   assign dot = sum_s;

endmodule

// File: rtl/conv_core_bitserial.sv
// ---------------------------------------------------------------------------
// conv_core_bitserial
// Bit-serial low-bit convolution core. Each accepted beat is processed as
// A*W cycles of (activation slice sa, weight slice sw) pairs; every cycle adds
// the per-OC slice dot product shifted by 2*(sa+sw) into the accumulators.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : beat input / result output channels (slave side)
//   busy       : FSM not in IDLE
//   cfg_err    : sticky, an unsupported act_bits/wgt_bits was seen on in_first
// ---------------------------------------------------------------------------
module conv_core_bitserial
   import lowbit_pkg::*;
#(
   parameter int IC_LANES = 16,
   parameter int OC_LANES = 16,
   parameter int KH       = 3,
   parameter int KW       = 3,
   parameter int ACC_W    = 48
) (
   input  logic                  clk,
   input  logic                  rst_n,
   conv_core_bitserial_if.slave  bus,
   output logic                  busy,
   output logic                  cfg_err
);

   localparam int N_TAPS = KH * KW * IC_LANES;
   localparam int DOT_W  = $clog2(9 * N_TAPS) + 2;

   state_t                               state_r, state_nxt_s;
   logic                                 in_ready_r, out_valid_r, busy_r, cfg_err_r;
   logic                                 last_r;
   logic [SCNT_W-1:0]                    a_n_r, w_n_r;
   logic [SLICE_W-1:0]                   sa_r, sw_r;
   logic [N_TAPS-1:0][OPND_W-1:0]        act_r;
   logic [OC_LANES-1:0][N_TAPS-1:0][OPND_W-1:0] wgt_r;
   logic [OC_LANES-1:0][ACC_W-1:0]       acc_r, acc_sum_s, term_s;
   logic                                 accept_s, out_take_s, sw_wrap_s, comp_last_s;
   slice_cfg_t                           act_cfg_s, wgt_cfg_s;
   logic [N_TAPS-1:0][1:0]               a_sl_s;
   logic [OC_LANES-1:0][N_TAPS-1:0][1:0] w_sl_s;
   logic signed [DOT_W-1:0]              dot_s [OC_LANES];
   logic [4:0]                           shamt_s;

   assign act_cfg_s   = bits_to_slices(bus.act_bits);
   assign wgt_cfg_s   = bits_to_slices(bus.wgt_bits);
   // sw is the inner counter; the group of A*W cycles ends on (A-1, W-1).
   assign sw_wrap_s   = ({1'b0, sw_r} == (w_n_r - 4'd1));
   assign comp_last_s = sw_wrap_s && ({1'b0, sa_r} == (a_n_r - 4'd1));

   // Next-state decode and handshake strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      out_take_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_COMP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_COMP: begin
            if (comp_last_s) begin
               state_nxt_s = last_r ? ST_OUT : ST_IDLE;
            end else begin
               state_nxt_s = ST_COMP;
            end
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               out_take_s  = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_OUT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Select the current 2-bit slice of every operand and the slice weight shift.
   always_comb begin
      a_sl_s  = '0;
      w_sl_s  = '0;
      shamt_s = {1'b0, sa_r, 1'b0} + {1'b0, sw_r, 1'b0};
      for (int i = 0; i < N_TAPS; i++) begin
         a_sl_s[i] = act_r[i][{sa_r, 1'b0} +: 2];
      end
      for (int oc = 0; oc < OC_LANES; oc++) begin
         for (int i = 0; i < N_TAPS; i++) begin
            w_sl_s[oc][i] = wgt_r[oc][i][{sw_r, 1'b0} +: 2];
         end
      end
   end

   for (genvar oc = 0; oc < OC_LANES; oc++) begin : g_lane
      conv_slice_dot #(
         .N_TAPS (N_TAPS),
         .DOT_W  (DOT_W)
      ) u_dot (
         .a_codes (a_sl_s),
         .w_codes (w_sl_s[oc]),
         .dot     (dot_s[oc])
      );
   end

   // Sign-extend, shift by slice weight and add; wraps modulo 2^ACC_W.
   always_comb begin
      term_s    = '0;
      acc_sum_s = '0;
      for (int oc = 0; oc < OC_LANES; oc++) begin
         term_s[oc]    = {{(ACC_W-DOT_W){dot_s[oc][DOT_W-1]}}, dot_s[oc]} << shamt_s;
         acc_sum_s[oc] = acc_r[oc] + term_s[oc];
      end
   end

   // FSM state and the flags derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         in_ready_r  <= (state_nxt_s == ST_IDLE);
         out_valid_r <= (state_nxt_s == ST_OUT);
         busy_r      <= (state_nxt_s != ST_IDLE);
      end
   end

   // Operand capture, group configuration and slice counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_r     <= '0;
         wgt_r     <= '0;
         last_r    <= 1'b0;
         sa_r      <= '0;
         sw_r      <= '0;
         a_n_r     <= 4'd1;
         w_n_r     <= 4'd1;
         cfg_err_r <= 1'b0;
      end else if (accept_s) begin
         act_r  <= bus.act;
         wgt_r  <= bus.wgt;
         last_r <= bus.in_last;
         sa_r   <= '0;
         sw_r   <= '0;
         if (bus.in_first) begin
            a_n_r     <= act_cfg_s.slices;
            w_n_r     <= wgt_cfg_s.slices;
            cfg_err_r <= cfg_err_r | act_cfg_s.illegal | wgt_cfg_s.illegal;
         end
      end else if (state_r == ST_COMP) begin
         if (sw_wrap_s) begin
            sw_r <= '0;
            sa_r <= sa_r + 3'd1;
         end else begin
            sw_r <= sw_r + 3'd1;
         end
      end
   end

   // Accumulators: cleared on group start and on result hand-off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= '0;
      end else if (accept_s && bus.in_first) begin
         acc_r <= '0;
      end else if (state_r == ST_COMP) begin
         acc_r <= acc_sum_s;
      end else if (out_take_s) begin
         acc_r <= '0;
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.partial   = acc_r;
   assign busy          = busy_r;
   assign cfg_err       = cfg_err_r;

endmodule

// File: tb/tb_conv_core_bitserial.sv
// ---------------------------------------------------------------------------
// tb_conv_core_bitserial
// Self-checking bench: directed table of constant-fill beats, hand-written
// multi-cycle sequences (multi-beat group, output stall, illegal config,
// reset during compute) and random groups checked against an operand-level
// arithmetic model.
// ---------------------------------------------------------------------------
module tb_conv_core_bitserial;

   localparam int IC = 16;
   localparam int OC = 16;
   localparam int KH = 3;
   localparam int KW = 3;
   localparam int AW = 48;
   localparam int NT = KH * KW * IC;
   localparam int TMO = 300;

   typedef logic [OC-1:0][AW-1:0] pvec_t;

   typedef struct {
      logic [4:0]        ab;
      logic [4:0]        wb;
      logic [1:0]        ac;
      logic [1:0]        wc;
      logic signed [47:0] exp;
      int                lat;
   } vec_t;

   logic clk;
   logic rst_n;
   logic busy;
   logic cfg_err;

   conv_core_bitserial_if #(.IC_LANES(IC), .OC_LANES(OC), .KH(KH), .KW(KW), .ACC_W(AW)) bus ();

   conv_core_bitserial #(
      .IC_LANES (IC),
      .OC_LANES (OC),
      .KH       (KH),
      .KW       (KW),
      .ACC_W    (AW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .busy    (busy),
      .cfg_err (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [NT-1:0][15:0]        act_v;
   logic [OC-1:0][NT-1:0][15:0] wgt_v;
   longint                     model_acc [OC];
   vec_t                       tbl [6];

   task automatic check_val(input string name, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic check_vec(input string name, input pvec_t got, input pvec_t exp);
      int bad;
      bad = -1;
      n_checks++;
      for (int oc = 0; oc < OC; oc++) begin
         if (got[oc] !== exp[oc] && bad < 0) bad = oc;
      end
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: lane %0d partial=%0d, expected %0d", name, bad,
                  $signed(got[bad]), $signed(exp[bad]));
      end
   endtask

   function automatic pvec_t rep(input logic signed [47:0] v);
      pvec_t r;
      for (int oc = 0; oc < OC; oc++) r[oc] = v;
      return r;
   endfunction

   function automatic int dec(input logic [1:0] c);
      case (c)
         2'b00:   return -3;
         2'b01:   return -1;
         2'b10:   return 1;
         default: return 3;
      endcase
   endfunction

   // Full operand value from its lowest n slices.
   function automatic longint opval(input logic [15:0] code, input int n);
      longint v;
      v = 0;
      for (int s = 0; s < n; s++) v += longint'(dec(code[2*s +: 2])) * (longint'(1) << (2*s));
      return v;
   endfunction

   task automatic model_add(input bit first, input int an, input int wn);
      longint av [NT];
      longint sum;
      for (int i = 0; i < NT; i++) av[i] = opval(act_v[i], an);
      for (int oc = 0; oc < OC; oc++) begin
         if (first) model_acc[oc] = 0;
         sum = 0;
         for (int i = 0; i < NT; i++) sum += av[i] * opval(wgt_v[oc][i], wn);
         model_acc[oc] += sum;
      end
   endtask

   function automatic pvec_t model_vec();
      pvec_t r;
      logic [63:0] t;
      for (int oc = 0; oc < OC; oc++) begin
         t = model_acc[oc];
         r[oc] = t[AW-1:0];
      end
      return r;
   endfunction

   task automatic fill_const(input logic [1:0] ac, input logic [1:0] wc);
      for (int i = 0; i < NT; i++) begin
         act_v[i] = {8{ac}};
         for (int oc = 0; oc < OC; oc++) wgt_v[oc][i] = {8{wc}};
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < NT; i++) begin
         act_v[i] = 16'($urandom);
         for (int oc = 0; oc < OC; oc++) wgt_v[oc][i] = 16'($urandom);
      end
   endtask

   // Present a beat and return #1 after the edge on which it was accepted.
   task automatic send(input bit first, input bit last, input logic [4:0] ab, input logic [4:0] wb);
      int w;
      bus.in_first = first;
      bus.in_last  = last;
      bus.act_bits = ab;
      bus.wgt_bits = wb;
      bus.act      = act_v;
      bus.wgt      = wgt_v;
      bus.in_valid = 1'b1;
      w = 0;
      while (!bus.in_ready && w < TMO) begin
         @(posedge clk); #1;
         w++;
      end
      check_val("accept_timeout", w < TMO, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Count edges from the accept edge until out_valid is seen.
   task automatic wait_out(input string name, input int lat);
      int n;
      n = 0;
      while (!bus.out_valid && n < TMO) begin
         @(posedge clk); #1;
         n++;
      end
      check_val({name, "_latency"}, n, lat);
   endtask

   // Non-last beat: must return to IDLE after lat edges without any output.
   task automatic wait_idle(input string name, input int lat);
      int n;
      bit saw;
      n = 0;
      saw = 1'b0;
      while (!bus.in_ready && n < TMO) begin
         @(posedge clk); #1;
         n++;
         if (bus.out_valid) saw = 1'b1;
      end
      check_val({name, "_idle_lat"}, n, lat);
      check_val({name, "_no_out"}, saw, 0);
   endtask

   task automatic take_out(input string name);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check_val({name, "_ov_drop"}, bus.out_valid, 0);
      check_val({name, "_rdy_back"}, bus.in_ready, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int an, wn, nb;
      logic [4:0] ab, wb;
      pvec_t held;

      tbl[0] = '{5'd2,  5'd2,  2'b11, 2'b11, 48'sd1296,         1};
      tbl[1] = '{5'd4,  5'd2,  2'b11, 2'b11, 48'sd6480,         2};
      tbl[2] = '{5'd4,  5'd2,  2'b00, 2'b11, -48'sd6480,        2};
      tbl[3] = '{5'd16, 5'd16, 2'b11, 2'b11, 48'sd618456416400, 64};
      tbl[4] = '{5'd8,  5'd4,  2'b10, 2'b01, -48'sd61200,       8};
      tbl[5] = '{5'd2,  5'd16, 2'b01, 2'b10, -48'sd3145680,     8};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_first  = 1'b0;
      bus.in_last   = 1'b0;
      bus.act_bits  = 5'd2;
      bus.wgt_bits  = 5'd2;
      bus.act       = '0;
      bus.wgt       = '0;
      bus.out_ready = 1'b0;
      act_v         = '0;
      wgt_v         = '0;
      for (int oc = 0; oc < OC; oc++) model_acc[oc] = 0;

      #22 rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("rst_in_ready", bus.in_ready, 1);
      check_val("rst_out_valid", bus.out_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_cfg_err", cfg_err, 0);
      check_vec("rst_partial", bus.partial, rep(48'sd0));

      // Directed single-beat groups with constant code fill.
      for (int k = 0; k < 6; k++) begin
         fill_const(tbl[k].ac, tbl[k].wc);
         send(1'b1, 1'b1, tbl[k].ab, tbl[k].wb);
         check_val($sformatf("tbl%0d_busy", k), busy, 1);
         wait_out($sformatf("tbl%0d", k), tbl[k].lat);
         check_val($sformatf("tbl%0d_busy_out", k), busy, 1);
         check_vec($sformatf("tbl%0d_partial", k), bus.partial, rep(tbl[k].exp));
         take_out($sformatf("tbl%0d", k));
         check_val($sformatf("tbl%0d_busy_idle", k), busy, 0);
      end

      // Two-beat group, then a fresh single-beat group.
      fill_const(2'b11, 2'b11);
      send(1'b1, 1'b0, 5'd2, 5'd2);
      wait_idle("grp_b1", 1);
      send(1'b0, 1'b1, 5'd2, 5'd2);
      wait_out("grp_b2", 1);
      check_vec("grp_partial", bus.partial, rep(48'sd2592));
      take_out("grp");
      send(1'b1, 1'b1, 5'd2, 5'd2);
      wait_out("grp_next", 1);
      check_vec("grp_next_partial", bus.partial, rep(48'sd1296));
      take_out("grp_next");

      // Output stall with a new beat waiting upstream.
      fill_const(2'b11, 2'b11);
      send(1'b1, 1'b1, 5'd4, 5'd2);
      wait_out("hold", 2);
      held = bus.partial;
      check_vec("hold_partial0", held, rep(48'sd6480));
      bus.in_valid = 1'b1;
      bus.in_first = 1'b1;
      bus.in_last  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check_val($sformatf("hold%0d_ov", c), bus.out_valid, 1);
         check_val($sformatf("hold%0d_in_ready", c), bus.in_ready, 0);
         check_vec($sformatf("hold%0d_partial", c), bus.partial, rep(48'sd6480));
      end
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
      take_out("hold");
      check_val("hold_not_accepted", busy, 0);

      // Random groups against the operand-level model.
      for (int g = 0; g < 6; g++) begin
         nb = $urandom_range(1, 3);
         an = 1;
         wn = 1;
         for (int b = 0; b < nb; b++) begin
            ab = 5'd2 << $urandom_range(0, 3);
            wb = 5'd2 << $urandom_range(0, 3);
            if (b == 0) begin
               an = int'(ab) / 2;
               wn = int'(wb) / 2;
            end
            fill_rand();
            model_add(b == 0, an, wn);
            send(b == 0, b == nb - 1, ab, wb);
            if (b == nb - 1) begin
               wait_out($sformatf("rnd%0d_%0d", g, b), an * wn);
               check_vec($sformatf("rnd%0d_partial", g), bus.partial, model_vec());
               take_out($sformatf("rnd%0d", g));
            end else begin
               wait_idle($sformatf("rnd%0d_%0d", g, b), an * wn);
            end
         end
      end

      // Illegal act_bits behaves as 2 bits and latches cfg_err.
      check_val("cfg_err_clear", cfg_err, 0);
      fill_const(2'b11, 2'b11);
      send(1'b1, 1'b1, 5'd6, 5'd2);
      wait_out("cfg_bad", 1);
      check_vec("cfg_bad_partial", bus.partial, rep(48'sd1296));
      check_val("cfg_err_set", cfg_err, 1);
      take_out("cfg_bad");
      send(1'b1, 1'b1, 5'd2, 5'd2);
      wait_out("cfg_good", 1);
      check_vec("cfg_good_partial", bus.partial, rep(48'sd1296));
      check_val("cfg_err_sticky", cfg_err, 1);
      take_out("cfg_good");

      // Reset during compute discards the group.
      send(1'b1, 1'b1, 5'd16, 5'd16);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check_val("midrst_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check_val("midrst_out_valid", bus.out_valid, 0);
      check_val("midrst_busy", busy, 0);
      check_val("midrst_in_ready", bus.in_ready, 1);
      check_val("midrst_cfg_err", cfg_err, 0);
      #5 rst_n = 1'b1;
      begin
         bit saw;
         saw = 1'b0;
         for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) saw = 1'b1;
         end
         check_val("midrst_no_output", saw, 0);
      end
      check_vec("midrst_partial", bus.partial, rep(48'sd0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_core_bitserial.md
Name: conv_core_bitserial

Overview:
- Next-generation low-bit convolution core. It time-multiplexes 2-bit activation/weight slices over cycles instead of splitting lanes spatially.
- Every IC/OC lane carries full-precision operands of up to 16 bits. Each compute cycle processes one (act slice, weight slice) pair, applies a shift of 2*(sa+sw) and accumulates.
- Partial sums can also be accumulated across several input beats (IC tiles) using first/last markers.
- Sits between the line-buffer/weight-fetch stage and the requant/output stage of the conv pipeline.

Parameters:
- IC_LANES, 16, input channels per beat
- OC_LANES, 16, output channels per beat
- KH, 3, kernel height
- KW, 3, kernel width
- ACC_W, 48, accumulator/output width, two's complement

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&in_ready
- in_first  in  1  beat starts a new accumulation group; clears accumulators
- in_last  in  1  beat ends group; result is emitted after compute
- act  in  16 x [KH][KW][IC_LANES]  packed codes; slice s = bits[2s+1:2s]
- wgt  in  16 x [OC_LANES][KH][KW][IC_LANES]  same packing
- act_bits  in  5  2/4/8/16, sampled on in_first beats
- wgt_bits  in  5  2/4/8/16, sampled on in_first beats
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready
- partial  out  ACC_W x [OC_LANES]  signed accumulated result
- busy  out  1  FSM not in IDLE
- cfg_err  out  1  sticky: illegal act_bits/wgt_bits seen; cleared only by reset

Behaviour:
- Reset (async, rst_n low) sets:
  - state=IDLE
  - all outputs 0 except in_ready=1
  - accumulators 0, latched config A=W=1
- decode2 mapping: 00->-3, 01->-1, 10->+1, 11->+3. Operand value = sum over s<A of decode2(slice s)*4^s. Slices at or above A/W are ignored.
- A = act_bits/2 and W = wgt_bits/2, latched on an accepted in_first beat.
  - An illegal value (not 2/4/8/16) is treated as 2 and sets cfg_err.
  - Beats without in_first reuse the latched config.
- FSM states: IDLE, COMP, OUT.
  - IDLE: in_ready=1. On handshake, latch act/wgt into operand registers and go to COMP with sa=sw=0. If in_first, clear accumulators first; the first slice adds onto zero.
  - COMP: in_ready=0. Each cycle, for every oc lane: acc += (sum over kh,kw,ic of decode2(a slice sa)*decode2(w slice sw)) <<< 2*(sa+sw).
    - Counter order: sw inner (0..W-1), sa outer (0..A-1). This gives exactly A*W cycles.
    - After the last cycle: go to OUT if the beat was in_last, else return to IDLE.
  - OUT: out_valid=1 and partial=acc, both held stable until out_ready. On handshake: out_valid falls, accumulators clear, state goes to IDLE.
- Latency: handshake at cycle T gives compute cycles T+1..T+A*W. For an in_last beat, out_valid rises at T+A*W+1.
- Throughput: one beat per A*W+1 cycles. An OUT state adds at least 1 cycle.
- Per-cycle dot term: magnitude at most 9*KH*KW*IC_LANES (1296 at defaults), so 12 bits + sign.
- Accumulation wraps modulo 2^ACC_W; no saturation. At defaults ACC_W=48 holds the 16x16-bit worst case exactly.
- Beat with in_first and in_last both set: a single-beat group.
- Beat with neither flag after reset: accumulates onto 0.
- in_valid while busy: ignored (in_ready=0); upstream holds it.
- Config pins changing mid-group: no effect until the next in_first beat.
- Reset asserted mid-COMP or mid-OUT: immediate return to reset values; the partial result is discarded.

Decomposition:
- Shared package lowbit_pkg holds:
  - decode2 function
  - state enum
  - slice-count helper (bits->slices, with illegal flag)
  - localparam MAX_SLICES=8
- Sub-module conv_slice_dot: combinational signed dot product over KH*KW*IC_LANES 2-bit code pairs, one instance per oc lane. Width is clog2(9*KH*KW*IC_LANES)+2.
- The core holds the FSM, slice counters, operand registers, shifter and accumulators.

Test Plan:
- Defaults, act_bits=wgt_bits=2, all codes 11, first&last. Required: out_valid at T+2, every partial=1296, busy high T+1..T+2.
- act_bits=4, wgt_bits=2, all codes 11 (operand values 15 and 3). Required: partial=6480 at T+3. Repeat with act codes 00 (value -15): partial=-6480.
- act_bits=wgt_bits=16, all codes 11. Required: partial=618456416400 after 64 compute cycles, out_valid at T+65.
- Two beats, 2-bit, all codes 11: beat 1 first-only, beat 2 last-only. Required: one output, partial=2592, and no out_valid after beat 1. A following first&last beat gives 1296, confirming the accumulators cleared.
- Hold out_ready=0 for 5 cycles in OUT. Required: partial and out_valid stable, in_ready=0, new in_valid not accepted. The handshake on cycle 6 returns to IDLE with in_ready=1.
- act_bits=6 on a first&last beat. Required: cfg_err=1 (stays 1 across later legal beats), computed as 2-bit, giving 1296. Separately, assert rst_n low during COMP. Required: out_valid=0, busy=0, in_ready=1 immediately, and no output is emitted afterwards.
